switch_bank: RTL

Parametrised memory-mapped switch input peripheral for the board's DIP-switch bank. Each raw switch input is synchronised and debounced per bit, and the block tracks changes per bit, with an optional interrupt. The CPU reads the result through the memorio chip-select path as a 16-bit data word. It replaces the fixed-width, undebounced switch reader.

---
 rtl/switch_pkg.sv | 13 +
 rtl/switch_debounce.sv | 39 +++
 rtl/switch_bank.sv | 82 ++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// switch_pkg: register-select encodings and data width shared by the switch bank files.
package switch_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        SW_ADDR_LO     = 2'b00,
        SW_ADDR_CHG_LO = 2'b01,
        SW_ADDR_HI     = 2'b10,
        SW_ADDR_CHG_HI = 2'b11
    } sw_addr_e;

endpackage

// File: rtl/switch_debounce.sv
// switch_debounce: one switch bit -- synchroniser chain, run-length debounce counter and accepted level.
// toggle pulses on the edge where the accepted level flips.
module switch_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic switclk,
    input  logic switrst,
    input  logic raw,
    output logic stable,
    output logic toggle
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_sh;
    logic [CW-1:0]          cnt;
    logic                   sync;
    logic                   differ;

    assign sync   = sync_sh[SYNC_STAGES-1];
    assign differ = sync != stable;
    assign toggle = differ && cnt == CNT_MAX;

    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            sync_sh <= '0;
            cnt     <= '0;
            stable  <= 1'b0;
        end else begin
            sync_sh <= {sync_sh[SYNC_STAGES-2:0], raw};
            cnt     <= (differ && !toggle) ? cnt + 1'b1 : '0;
            if (toggle)
                stable <= sync;
        end
    end

endmodule

// File: rtl/switch_bank.sv
// switch_bank: debounced DIP-switch bank read through the memorio chip-select path.
// Define SWITCH_EDGE_IRQ_EN to add sticky per-bit change flags and the switirq interrupt.
module switch_bank
    import switch_pkg::*;
#(
    parameter int WIDTH           = 24,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic              switclk,
    input  logic              switrst,
    input  logic              switcs,
    input  logic              switread,
    input  logic [1:0]        switaddr,
    input  logic [WIDTH-1:0]  switch_rdata,
    output logic [DATA_W-1:0] switch_wdata,
    output logic              switirq
);

    logic [WIDTH-1:0]  stable;
    logic [WIDTH-1:0]  tog;
    logic [31:0]       st_ext;
    logic [31:0]       chg_ext;
    logic [DATA_W-1:0] rd_mux;
    logic              rd;

    assign rd     = switcs && switread;
    assign st_ext = 32'(stable);

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        switch_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .switclk(switclk),
            .switrst(switrst),
            .raw    (switch_rdata[g]),
            .stable (stable[g]),
            .toggle (tog[g])
        );
    end

`ifdef SWITCH_EDGE_IRQ_EN
    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] clr;

    assign chg_ext = 32'(chg);
    assign clr = (rd && switaddr == SW_ADDR_CHG_LO) ? WIDTH'(32'h0000_FFFF) :
                 (rd && switaddr == SW_ADDR_CHG_HI) ? WIDTH'(32'hFFFF_0000) : '0;

    // A transition on the same edge as a read-clear keeps its flag set.
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            chg     <= '0;
            switirq <= 1'b0;
        end else begin
            chg     <= tog | (chg & ~clr);
            switirq <= |chg;
        end
    end
`else
    logic unused_tog;

    assign chg_ext    = '0;
    assign switirq    = 1'b0;
    assign unused_tog = ^tog;
`endif

    always_comb begin
        rd_mux = (switaddr == SW_ADDR_LO)     ? st_ext[15:0]  :
                 (switaddr == SW_ADDR_HI)     ? st_ext[31:16] :
                 (switaddr == SW_ADDR_CHG_LO) ? chg_ext[15:0] : chg_ext[31:16];
    end

    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst)
            switch_wdata <= '0;
        else if (rd)
            switch_wdata <= rd_mux;
    end

endmodule
